// File: rtl/order_pkg.sv
// Shared types and widths for the order engine: game FSM states, field widths
// and the saturating score helper used on delivery.
package order_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } game_state_t;

  localparam int ORDER_TIME_W = 5;
  localparam int SCORE_W      = 10;
  localparam int MISS_W       = 6;
  localparam int GAME_W       = 8;

  // Delivery is worth 1 point plus a bonus of one point per 8 remaining steps.
  function automatic logic [SCORE_W-1:0] score_add(
    input logic [SCORE_W-1:0]      score,
    input logic [ORDER_TIME_W-1:0] time_left
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, score} + (SCORE_W+1)'(1) + (SCORE_W+1)'(time_left >> 3);
    if (sum[SCORE_W]) begin
      score_add = '1;
    end else begin
      score_add = sum[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides the pixel clock down to one-cycle countdown step ticks.
// The count only advances while enabled and is zeroed by clr_in.
module step_prescaler #(
  parameter int TICKS_PER_STEP = 12_500_000
) (
  input  logic pixel_clk_in,
  input  logic rst_n_in,
  input  logic en_in,
  input  logic clr_in,
  output logic step_tick_out
);

  localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_STEP - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
    end else if (clr_in) begin
      r_cnt <= '0;
    end else if (en_in) begin
      if (w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign step_tick_out = en_in && !clr_in && w_wrap;

endmodule

// File: rtl/order_manager.sv
// Game-side order engine: spawns orders into slots, counts them down per step,
// retires them on delivery or expiry, and tracks score, misses and round time.
module order_manager
  import order_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int TICKS_PER_STEP = 12_500_000,
  parameter int ORDER_TIME_MAX = 31,
  parameter int SPAWN_STEPS    = 8,
  parameter int GAME_STEPS     = 240
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_n_in,
  input  logic                             start_in,
  input  logic                             deliver_in,
  output logic [NUM_SLOTS-1:0]             order_out,
  output logic [NUM_SLOTS*ORDER_TIME_W-1:0] order_time_out,
  output logic [SCORE_W-1:0]               score_out,
  output logic [MISS_W-1:0]                missed_out,
  output logic [GAME_W-1:0]                game_time_out,
  output logic                             playing_out,
  output logic                             reject_out
);

  localparam int SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int SPAWN_W = $clog2(SPAWN_STEPS + 1);
  localparam logic [SPAWN_W-1:0]      SPAWN_MAX = SPAWN_W'(SPAWN_STEPS);
  localparam logic [ORDER_TIME_W-1:0] TIME_INIT = ORDER_TIME_W'(ORDER_TIME_MAX);
  localparam logic [GAME_W-1:0]       GAME_INIT = GAME_W'(GAME_STEPS);

  game_state_t                                r_state, w_state_nxt;
  logic [NUM_SLOTS-1:0]                       r_order, w_order_nxt;
  logic [NUM_SLOTS-1:0][ORDER_TIME_W-1:0]     r_time, w_time_nxt;
  logic [SCORE_W-1:0]                         r_score, w_score_nxt;
  logic [MISS_W-1:0]                          r_missed, w_missed_nxt;
  logic [GAME_W-1:0]                          r_game_time, w_game_time_nxt;
  logic [SPAWN_W-1:0]                         r_spawn_cnt, w_spawn_nxt;
  logic                                       r_playing, w_playing_nxt;
  logic                                       r_reject, w_reject_nxt;

  logic                    w_run;
  logic                    w_tick;
  logic                    w_found;
  logic [SLOT_W-1:0]       w_tgt;
  logic [ORDER_TIME_W-1:0] w_best;
  logic                    w_free_found;
  logic [SLOT_W-1:0]       w_free_idx;
  logic                    w_deliver_hit;
  logic [NUM_SLOTS-1:0]    w_expire;
  logic [3:0]              w_n_expire;
  logic [MISS_W:0]         w_miss_sum;

  assign w_run = (r_state == RUN);

  step_prescaler #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_prescaler (
    .pixel_clk_in (pixel_clk_in),
    .rst_n_in     (rst_n_in),
    .en_in        (w_run),
    .clr_in       (start_in),
    .step_tick_out(w_tick)
  );

  // Delivery target: active slot with the least time left; strict '<' keeps the lowest index on ties.
  always_comb begin
    w_found = 1'b0;
    w_tgt   = '0;
    w_best  = '1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_order[i] && (!w_found || (r_time[i] < w_best))) begin
        w_found = 1'b1;
        w_tgt   = SLOT_W'(i);
        w_best  = r_time[i];
      end
    end
  end

  // Only slots already free at the start of the cycle are spawn candidates.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_order[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = SLOT_W'(i);
      end
    end
  end

  assign w_deliver_hit = w_run && !start_in && deliver_in && w_found;

  always_comb begin
    w_n_expire = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_expire[i] = w_run && !start_in && w_tick && r_order[i] && (r_time[i] == ORDER_TIME_W'(1))
                    && !(w_deliver_hit && (w_tgt == SLOT_W'(i)));
      w_n_expire  = w_n_expire + 4'(w_expire[i]);
    end
  end

  assign w_miss_sum = {1'b0, r_missed} + (MISS_W+1)'(w_n_expire);

  always_comb begin
    w_state_nxt     = r_state;
    w_order_nxt     = r_order;
    w_time_nxt      = r_time;
    w_score_nxt     = r_score;
    w_missed_nxt    = r_missed;
    w_game_time_nxt = r_game_time;
    w_spawn_nxt     = r_spawn_cnt;
    w_reject_nxt    = 1'b0;

    case (r_state)
      RUN: begin
        if (w_tick) begin
          w_game_time_nxt = r_game_time - GAME_W'(1);
          if (r_game_time == GAME_W'(1)) begin
            w_state_nxt = DONE;
          end
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_order[i]) begin
              if (r_time[i] > ORDER_TIME_W'(1)) begin
                w_time_nxt[i] = r_time[i] - ORDER_TIME_W'(1);
              end else begin
                w_order_nxt[i] = 1'b0;
                w_time_nxt[i]  = '0;
              end
            end
          end
          if ((r_spawn_cnt == SPAWN_MAX) && w_free_found && (r_game_time != GAME_W'(1))) begin
            w_order_nxt[w_free_idx] = 1'b1;
            w_time_nxt[w_free_idx]  = TIME_INIT;
            w_spawn_nxt             = SPAWN_W'(1);
          end else if (r_spawn_cnt < SPAWN_MAX) begin
            w_spawn_nxt = r_spawn_cnt + SPAWN_W'(1);
          end
        end
        if (deliver_in) begin
          if (w_found) begin
            w_order_nxt[w_tgt] = 1'b0;
            w_time_nxt[w_tgt]  = '0;
            w_score_nxt        = score_add(r_score, r_time[w_tgt]);
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
        w_missed_nxt = (w_miss_sum > (MISS_W+1)'({MISS_W{1'b1}})) ? '1 : w_miss_sum[MISS_W-1:0];
      end
      default: ;
    endcase

    // Entering RUN (from any state) always starts a fresh round.
    if (start_in) begin
      w_state_nxt     = RUN;
      w_order_nxt     = '0;
      w_time_nxt      = '0;
      w_score_nxt     = '0;
      w_missed_nxt    = '0;
      w_game_time_nxt = GAME_INIT;
      w_spawn_nxt     = SPAWN_MAX;
      w_reject_nxt    = 1'b0;
    end

    w_playing_nxt = (w_state_nxt == RUN);
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= IDLE;
      r_order     <= '0;
      r_time      <= '0;
      r_score     <= '0;
      r_missed    <= '0;
      r_game_time <= '0;
      r_spawn_cnt <= '0;
      r_playing   <= 1'b0;
      r_reject    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_order     <= w_order_nxt;
      r_time      <= w_time_nxt;
      r_score     <= w_score_nxt;
      r_missed    <= w_missed_nxt;
      r_game_time <= w_game_time_nxt;
      r_spawn_cnt <= w_spawn_nxt;
      r_playing   <= w_playing_nxt;
      r_reject    <= w_reject_nxt;
    end
  end

  assign order_out      = r_order;
  assign order_time_out = r_time;
  assign score_out      = r_score;
  assign missed_out     = r_missed;
  assign game_time_out  = r_game_time;
  assign playing_out    = r_playing;
  assign reject_out     = r_reject;

endmodule

// File: tb/tb_order_manager.sv
// Directed bench for order_manager: a fast-step main instance plus a second
// instance with a short spawn interval so all slots can be full at a spawn step.
module tb_order_manager;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, deliver1, start2, deliver2;

  logic [3:0]  order1, order2;
  logic [19:0] time1, time2;
  logic [9:0]  score1, score2;
  logic [5:0]  missed1, missed2;
  logic [7:0]  gt1, gt2;
  logic        play1, play2, rej1, rej2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  order_manager #(
    .NUM_SLOTS(4), .TICKS_PER_STEP(4), .ORDER_TIME_MAX(31), .SPAWN_STEPS(8), .GAME_STEPS(240)
  ) u_dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .deliver_in(deliver1),
    .order_out(order1), .order_time_out(time1), .score_out(score1), .missed_out(missed1),
    .game_time_out(gt1), .playing_out(play1), .reject_out(rej1)
  );

  order_manager #(
    .NUM_SLOTS(4), .TICKS_PER_STEP(4), .ORDER_TIME_MAX(31), .SPAWN_STEPS(2), .GAME_STEPS(240)
  ) u_dut_fast (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .start_in(start2), .deliver_in(deliver2),
    .order_out(order2), .order_time_out(time2), .score_out(score2), .missed_out(missed2),
    .game_time_out(gt2), .playing_out(play2), .reject_out(rej2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [4:0] slot_t(input logic [19:0] v, input int i);
    return v[i*5 +: 5];
  endfunction

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic adv_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic start_round1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 0;
  endtask

  task automatic deliver1_at(input int c);
    adv_to(c - 1);
    deliver1 = 1'b1;
    tick();
    deliver1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; deliver1 = 1'b0; start2 = 1'b0; deliver2 = 1'b0;
    repeat (3) tick();
    check("rst_order", 32'(order1), 0);
    check("rst_time", 32'(time1), 0);
    check("rst_score", 32'(score1), 0);
    check("rst_missed", 32'(missed1), 0);
    check("rst_game_time", 32'(gt1), 0);
    check("rst_playing", 32'(play1), 0);
    check("rst_reject", 32'(rej1), 0);
    rst_n = 1'b1;
    tick();

    // Round A: no deliveries, fill order and first expiry
    start_round1();
    check("a_playing", 32'(play1), 1);
    check("a_game_time", 32'(gt1), 240);
    check("a_order0", 32'(order1), 0);
    adv_to(3);
    check("a_pre_step_order", 32'(order1), 0);
    adv_to(4);
    check("a_s1_order", 32'(order1), 4'b0001);
    check("a_s1_t0", 32'(slot_t(time1, 0)), 31);
    check("a_s1_game_time", 32'(gt1), 239);
    adv_to(36);
    check("a_s9_order", 32'(order1), 4'b0011);
    check("a_s9_t1", 32'(slot_t(time1, 1)), 31);
    check("a_s9_t0", 32'(slot_t(time1, 0)), 23);
    adv_to(100);
    check("a_s25_order", 32'(order1), 4'b1111);
    check("a_s25_t3", 32'(slot_t(time1, 3)), 31);
    check("a_s25_t0", 32'(slot_t(time1, 0)), 7);
    adv_to(124);
    check("a_s31_t0", 32'(slot_t(time1, 0)), 1);
    check("a_s31_missed", 32'(missed1), 0);
    adv_to(128);
    check("a_s32_order", 32'(order1), 4'b1110);
    check("a_s32_missed", 32'(missed1), 1);
    check("a_s32_t0", 32'(slot_t(time1, 0)), 0);
    adv_to(132);
    check("a_s33_order", 32'(order1), 4'b1111);
    check("a_s33_t0", 32'(slot_t(time1, 0)), 31);

    // Round B: restart mid-round, deliveries, reject, deliver-vs-expiry, round end
    start_round1();
    check("b_order", 32'(order1), 0);
    check("b_score", 32'(score1), 0);
    check("b_missed", 32'(missed1), 0);
    check("b_game_time", 32'(gt1), 240);
    check("b_playing", 32'(play1), 1);
    adv_to(48);
    check("b_s12_t0", 32'(slot_t(time1, 0)), 20);
    check("b_s12_t1", 32'(slot_t(time1, 1)), 28);
    deliver1_at(50);
    check("b_dlv_order", 32'(order1), 4'b0010);
    check("b_dlv_score", 32'(score1), 3);
    check("b_dlv_t1", 32'(slot_t(time1, 1)), 28);
    check("b_dlv_reject", 32'(rej1), 0);
    adv_to(52);
    check("b_s13_t1", 32'(slot_t(time1, 1)), 27);
    deliver1_at(53);
    check("b_dlv2_order", 32'(order1), 0);
    check("b_dlv2_score", 32'(score1), 7);
    deliver1_at(54);
    check("b_rej_pulse", 32'(rej1), 1);
    check("b_rej_score", 32'(score1), 7);
    tick();
    check("b_rej_end", 32'(rej1), 0);
    adv_to(68);
    check("b_s17_order", 32'(order1), 4'b0001);
    check("b_s17_t0", 32'(slot_t(time1, 0)), 31);
    adv_to(188);
    check("b_s47_order", 32'(order1), 4'b1111);
    check("b_s47_t0", 32'(slot_t(time1, 0)), 1);
    check("b_s47_t1", 32'(slot_t(time1, 1)), 9);
    deliver1_at(192);
    check("b_race_order", 32'(order1), 4'b1110);
    check("b_race_score", 32'(score1), 8);
    check("b_race_missed", 32'(missed1), 0);
    check("b_race_t1", 32'(slot_t(time1, 1)), 8);
    adv_to(196);
    check("b_s49_order", 32'(order1), 4'b1111);
    check("b_s49_t0", 32'(slot_t(time1, 0)), 31);
    adv_to(956);
    check("b_s239_game_time", 32'(gt1), 1);
    check("b_s239_playing", 32'(play1), 1);
    adv_to(960);
    check("b_end_playing", 32'(play1), 0);
    check("b_end_game_time", 32'(gt1), 0);
    check("b_end_order", 32'(order1), 4'b1110);
    check("b_end_missed", 32'(missed1), 24);
    check("b_end_score", 32'(score1), 8);
    check("b_end_t1", 32'(slot_t(time1, 1)), 8);
    check("b_end_t2", 32'(slot_t(time1, 2)), 16);
    check("b_end_t3", 32'(slot_t(time1, 3)), 24);
    adv_to(976);
    deliver1_at(977);
    check("done_reject", 32'(rej1), 0);
    check("done_order", 32'(order1), 4'b1110);
    check("done_t1", 32'(slot_t(time1, 1)), 8);
    check("done_score", 32'(score1), 8);
    check("done_missed", 32'(missed1), 24);
    check("done_game_time", 32'(gt1), 0);
    check("done_playing", 32'(play1), 0);

    // Restart from DONE with a simultaneous deliver: start wins
    start1 = 1'b1;
    deliver1 = 1'b1;
    tick();
    start1 = 1'b0;
    deliver1 = 1'b0;
    check("c_playing", 32'(play1), 1);
    check("c_game_time", 32'(gt1), 240);
    check("c_order", 32'(order1), 0);
    check("c_score", 32'(score1), 0);
    check("c_missed", 32'(missed1), 0);
    check("c_reject", 32'(rej1), 0);

    // Fast-spawn instance: all slots full at a spawn step, refill only on the next step
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 0;
    adv_to(28);
    check("f_s7_order", 32'(order2), 4'b1111);
    adv_to(36);
    check("f_s9_order", 32'(order2), 4'b1111);
    check("f_s9_t0", 32'(slot_t(time2, 0)), 23);
    adv_to(37);
    deliver2 = 1'b1;
    tick();
    deliver2 = 1'b0;
    check("f_dlv_order", 32'(order2), 4'b1110);
    check("f_dlv_score", 32'(score2), 3);
    adv_to(40);
    check("f_s10_order", 32'(order2), 4'b1111);
    check("f_s10_t0", 32'(slot_t(time2, 0)), 31);
    check("f_s10_t1", 32'(slot_t(time2, 1)), 24);
    check("f_s10_score", 32'(score2), 3);

    // Asynchronous reset mid-round, observed before any clock edge
    check("r_pre_playing", 32'(play1), 1);
    rst_n = 1'b0;
    #2;
    check("r_order", 32'(order1), 0);
    check("r_time", 32'(time1), 0);
    check("r_game_time", 32'(gt1), 0);
    check("r_playing", 32'(play1), 0);
    check("r_score", 32'(score1), 0);
    check("r_fast_order", 32'(order2), 0);
    check("r_fast_score", 32'(score2), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
